lifo_stream_reader: RTL and testbench
=====================================

Name: lifo_stream_reader

Overview:
- Downstream consumer of the lifo block: on command, pops a burst of up to N words from the stack and presents them on a valid/ready stream with a last-word marker.
- Hides the lifo's one-cycle read latency behind a 2-entry skid buffer, so stream backpressure never loses or duplicates a word.
- Sustains 1 word/cycle when ready_i stays high.

Parameters:
- DWIDTH, 16, data width; matches the lifo DWIDTH.
- AWIDTH, 8, lifo address width; lifo depth is 2**AWIDTH and burst length is AWIDTH+1 bits.

Ports:
- clk_i  in  1  clock
- srst_i  in  1  reset; asynchronous, active-high
- start_i  in  1  burst request; sampled only in IDLE
- len_i  in  AWIDTH+1  requested word count; sampled with start_i
- busy_o  out  1  high from the cycle after start is accepted until done
- done_o  out  1  one-cycle pulse at burst end
- short_o  out  1  valid with done_o; burst was clipped to lifo occupancy
- lifo_rdreq_o  out  1  pop strobe to the lifo
- lifo_q_i  in  DWIDTH  lifo read data; valid 1 cycle after lifo_rdreq_o
- lifo_empty_i  in  1  lifo empty flag
- lifo_usedw_i  in  AWIDTH+1  lifo occupancy
- data_o  out  DWIDTH  stream data
- valid_o  out  1  stream valid
- ready_i  in  1  stream ready
- last_o  out  1  high with the final word of the burst

Behaviour:
- Reset (async, immediate): state IDLE; busy_o, done_o, short_o, lifo_rdreq_o, valid_o, last_o = 0; data_o = 0; all counters and buffer entries cleared.
- Reset mid-burst: outstanding lifo read data is discarded. Words already popped are lost; this is accepted.
- FSM has 2 states.
- IDLE: on start_i, latch remaining = min(len_i, lifo_usedw_i). Latch short = (len_i > lifo_usedw_i). Go to RUN.
  - If the latched remaining = 0, stay in IDLE and pulse done_o the next cycle, with short_o = short. No rdreq is issued and valid_o stays 0.
- RUN: busy_o = 1; start_i is ignored.
- Credit rule: lifo_rdreq_o = (remaining != 0) && !lifo_empty_i && (buf_cnt + inflight - pop) < 2.
  - pop = valid_o && ready_i.
  - inflight = registered copy of the previous cycle's lifo_rdreq_o.
  - Each rdreq decrements remaining.
- Capture: when inflight = 1, lifo_q_i is written into the skid buffer (FIFO order, 2 entries). The buffer never overflows; the bench asserts this.
- Stream output:
  - valid_o = (buf_cnt != 0); data_o = head entry.
  - Data is held stable while valid_o && !ready_i.
  - last_o = valid_o && remaining = 0 && inflight = 0 && buf_cnt = 1.
- Latency with ready_i high:
  - start_i sampled at edge T.
  - lifo_rdreq_o high in cycle T+1.
  - First valid_o in cycle T+3.
  - One word per cycle thereafter.
- Exit: the handshake on the last_o word moves RUN to IDLE. done_o pulses in the following cycle, with short_o valid in that same cycle. busy_o drops together with the done_o pulse.
- Output order is pop order, i.e. most recently pushed word first.
- Upstream must not push to the lifo while busy_o = 1. If it does, word count is still honoured but word identity is undefined.
- If lifo_empty_i rises unexpectedly while remaining > 0, rdreq stalls; the block does not error.

Test Plan:
- Lifo model with 1-cycle read latency. Push A=0x1111, B=0x2222, C=0x3333, D=0x4444. Start len=4, ready_i=1 -> data_o D,C,B,A on 4 consecutive cycles from T+3; last_o with A; done_o 1 cycle later; short_o=0; usedw=0.
- Same preload; ready_i pattern 1,0,0,1,0,1,1 -> exactly D,C,B,A accepted, no duplicates, data stable during stalls; buffer occupancy never above 2; rdreq never issued with 2 words pending.
- Preload 3 words, start len=10 -> 3 words output, last_o on the 3rd, done_o with short_o=1.
- start_i with len=0 (and separately with an empty lifo, len=5) -> no rdreq, no valid_o, done_o pulse next cycle; short_o=0 and 1 respectively.
- Fill lifo to 2**AWIDTH=256 words; start len=256 with random ready_i -> 256 words in exact reverse push order; last_o only on the final word; lifo empty at done_o.
- Assert srst_i asynchronously mid-burst (after 5 of 20 words) -> all outputs 0 before the next clock edge. Then a new preload of 2 words with start len=2 outputs both words correctly. A start_i pulse while busy_o=1 is ignored (no extra words, single done_o).

Source files
------------

// File: rtl/lifo_stream_reader.sv
// Pops a burst of up to len_i words from a lifo with one-cycle read latency and
// streams them out over valid/ready through a 2-entry skid buffer.
module lifo_stream_reader #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              start_i,
  input  logic [AWIDTH:0]   len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              short_o,
  output logic              lifo_rdreq_o,
  input  logic [DWIDTH-1:0] lifo_q_i,
  input  logic              lifo_empty_i,
  input  logic [AWIDTH:0]   lifo_usedw_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [AWIDTH:0] LEN_ZERO = {(AWIDTH+1){1'b0}};
  localparam logic [AWIDTH:0] LEN_ONE  = {{AWIDTH{1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AWIDTH:0]     r_remaining;
  logic                r_short;
  logic                r_inflight;
  logic [1:0]          r_buf_cnt;
  logic [DWIDTH-1:0]   r_buf0;
  logic [DWIDTH-1:0]   r_buf1;
  logic                r_done;
  logic                r_short_o;

  logic [AWIDTH:0]     w_len_clip;
  logic                w_short_new;
  logic                w_valid;
  logic                w_pop;
  logic                w_last;
  logic                w_busy;
  logic                w_rdreq;
  logic [2:0]          w_credit;

  assign w_short_new = (len_i > lifo_usedw_i);
  assign w_len_clip  = w_short_new ? lifo_usedw_i : len_i;
  assign w_valid     = (r_buf_cnt != 2'd0);
  assign w_pop       = w_valid && ready_i;
  assign w_last      = w_valid && (r_remaining == LEN_ZERO) && !r_inflight && (r_buf_cnt == 2'd1);
  // Words already owed to the buffer (stored plus in flight) after this cycle's pop.
  assign w_credit    = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};

  assign busy_o       = w_busy;
  assign lifo_rdreq_o = w_rdreq;
  assign done_o       = r_done;
  assign short_o      = r_short_o;
  assign data_o       = r_buf0;
  assign valid_o      = w_valid;
  assign last_o       = w_last;

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i && (w_len_clip != LEN_ZERO)) w_state_nxt = S_RUN;
        else                                     w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (w_pop && w_last) w_state_nxt = S_IDLE;
        else                 w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy  = 1'b0;
    w_rdreq = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy  = 1'b0;
        w_rdreq = 1'b0;
      end
      S_RUN: begin
        w_busy  = 1'b1;
        w_rdreq = (r_remaining != LEN_ZERO) && !lifo_empty_i && (w_credit < 3'd2);
      end
      default: begin
        w_busy  = 1'b0;
        w_rdreq = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_remaining <= LEN_ZERO;
      r_short     <= 1'b0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
      r_short_o   <= 1'b0;
    end else begin
      r_inflight <= w_rdreq;
      r_done     <= 1'b0;
      r_short_o  <= 1'b0;
      if ((r_state == S_IDLE) && start_i) begin
        r_remaining <= w_len_clip;
        r_short     <= w_short_new;
        if (w_len_clip == LEN_ZERO) begin
          r_done    <= 1'b1;
          r_short_o <= w_short_new;
        end
      end else if (w_rdreq) begin
        r_remaining <= r_remaining - LEN_ONE;
      end
      if ((r_state == S_RUN) && w_pop && w_last) begin
        r_done    <= 1'b1;
        r_short_o <= r_short;
      end
    end
  end

  // Skid buffer: entry 0 is the head; capture and pop may happen in the same cycle.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_buf_cnt <= 2'd0;
      r_buf0    <= {DWIDTH{1'b0}};
      r_buf1    <= {DWIDTH{1'b0}};
    end else begin
      case ({r_inflight, w_pop})
        2'b11: begin
          if (r_buf_cnt == 2'd1) begin
            r_buf0 <= lifo_q_i;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= lifo_q_i;
          end
        end
        2'b10: begin
          if (r_buf_cnt == 2'd0) r_buf0 <= lifo_q_i;
          else                   r_buf1 <= lifo_q_i;
          r_buf_cnt <= r_buf_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0    <= r_buf1;
          r_buf_cnt <= r_buf_cnt - 2'd1;
        end
        default: begin
          r_buf_cnt <= r_buf_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_stream_reader.sv
// Directed bench for lifo_stream_reader: a behavioural lifo with one-cycle read
// latency, per-cycle vector tables and hand-written burst sequences.
module tb_lifo_stream_reader;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          srst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [AW:0]   len_i = '0;
  logic          busy_o, done_o, short_o, lifo_rdreq_o, valid_o, last_o;
  logic [DW-1:0] lifo_q_i;
  logic          lifo_empty_i;
  logic [AW:0]   lifo_usedw_i;
  logic [DW-1:0] data_o;
  logic          ready_i = 1'b0;

  logic [DW-1:0] mem [0:255];
  logic [AW:0]   lcnt = '0;
  logic          push_en = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic [DW-1:0] lq = '0;

  int errors = 0;
  int checks = 0;
  int issued = 0;
  int accepted = 0;

  typedef struct {
    logic          ready;
    logic          rdreq;
    logic          valid;
    logic [DW-1:0] data;
    logic          last;
    logic          busy;
    logic          done;
    logic          shrt;
  } vec_t;

  vec_t t1[7];
  vec_t t2[9];

  always #5 clk = ~clk;

  lifo_stream_reader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk_i(clk), .srst_i(srst_i), .start_i(start_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .short_o(short_o),
    .lifo_rdreq_o(lifo_rdreq_o), .lifo_q_i(lifo_q_i),
    .lifo_empty_i(lifo_empty_i), .lifo_usedw_i(lifo_usedw_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o)
  );

  // Behavioural lifo: read data appears one cycle after the pop strobe.
  always @(posedge clk) begin
    if (push_en) begin
      mem[int'(lcnt)] <= push_data;
      lcnt <= lcnt + 9'd1;
    end else if (lifo_rdreq_o && lcnt != 9'd0) begin
      lq   <= mem[int'(lcnt) - 1];
      lcnt <= lcnt - 9'd1;
    end
  end
  assign lifo_q_i     = lq;
  assign lifo_empty_i = (lcnt == 9'd0);
  assign lifo_usedw_i = lcnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    @(posedge clk); #1;
    push_en = 1'b1; push_data = w;
    @(posedge clk); #1;
    push_en = 1'b0;
  endtask

  task automatic do_start(input logic [AW:0] len);
    @(posedge clk); #1;
    start_i = 1'b1; len_i = len; ready_i = 1'b1;
  endtask

  // Words owed to the stream must stay within the 2-entry buffer.
  task automatic monitor();
    int p;
    p = (valid_o && ready_i) ? 1 : 0;
    if (lifo_rdreq_o) chk("credit", 32'((issued - accepted - p) < 2), 32'd1);
    issued   += lifo_rdreq_o ? 1 : 0;
    accepted += p;
  endtask

  task automatic apply_vec(input vec_t v, input string tag, input int i);
    @(posedge clk); #1;
    start_i = 1'b0; ready_i = v.ready;
    #1;
    monitor();
    chk($sformatf("%s[%0d] rdreq", tag, i), 32'(lifo_rdreq_o), 32'(v.rdreq));
    chk($sformatf("%s[%0d] valid", tag, i), 32'(valid_o), 32'(v.valid));
    chk($sformatf("%s[%0d] last", tag, i), 32'(last_o), 32'(v.last));
    chk($sformatf("%s[%0d] busy", tag, i), 32'(busy_o), 32'(v.busy));
    chk($sformatf("%s[%0d] done", tag, i), 32'(done_o), 32'(v.done));
    if (v.valid) chk($sformatf("%s[%0d] data", tag, i), 32'(data_o), 32'(v.data));
    if (v.done)  chk($sformatf("%s[%0d] short", tag, i), 32'(short_o), 32'(v.shrt));
  endtask

  task automatic run_burst(input logic [AW:0] len, input bit rnd, input bit mid_start,
                           input logic exp_short, input string tag);
    logic [DW-1:0] expq[$];
    int n, k, rq;
    bit got_done;
    n = (int'(len) < int'(lcnt)) ? int'(len) : int'(lcnt);
    for (int j = 0; j < n; j++) expq.push_back(mem[int'(lcnt) - 1 - j]);
    do_start(len);
    k = 0; rq = 0; got_done = 1'b0;
    for (int cyc = 0; cyc < 4000 && !got_done; cyc++) begin
      @(posedge clk); #1;
      start_i = mid_start && (cyc == 3);
      if (start_i) len_i = 9'd5;
      ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      monitor();
      if (start_i) chk({tag, " busy at extra start"}, 32'(busy_o), 32'd1);
      rq += lifo_rdreq_o ? 1 : 0;
      if (valid_o && ready_i) begin
        if (k < n) begin
          chk($sformatf("%s word%0d data", tag, k), 32'(data_o), 32'(expq[k]));
          chk($sformatf("%s word%0d last", tag, k), 32'(last_o), 32'(k == n - 1));
        end else begin
          chk({tag, " extra word"}, 32'd1, 32'd0);
        end
        k++;
      end
      if (done_o) begin
        got_done = 1'b1;
        chk({tag, " word count"}, 32'(k), 32'(n));
        chk({tag, " rdreq count"}, 32'(rq), 32'(n));
        chk({tag, " short"}, 32'(short_o), 32'(exp_short));
        chk({tag, " busy at done"}, 32'(busy_o), 32'd0);
      end
    end
    start_i = 1'b0;
    if (!got_done) chk({tag, " done timeout"}, 32'd0, 32'd1);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #2;
      chk({tag, " single done"}, 32'(done_o), 32'd0);
      chk({tag, " idle valid"}, 32'(valid_o), 32'd0);
    end
  endtask

  initial begin
    int acc;
    t1[0] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    t1[1] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    t1[2] = '{1'b1, 1'b1, 1'b1, 16'h4444, 1'b0, 1'b1, 1'b0, 1'b0};
    t1[3] = '{1'b1, 1'b1, 1'b1, 16'h3333, 1'b0, 1'b1, 1'b0, 1'b0};
    t1[4] = '{1'b1, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b0};
    t1[5] = '{1'b1, 1'b0, 1'b1, 16'h1111, 1'b1, 1'b1, 1'b0, 1'b0};
    t1[6] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};

    t2[0] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    t2[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    t2[2] = '{1'b0, 1'b0, 1'b1, 16'h4444, 1'b0, 1'b1, 1'b0, 1'b0};
    t2[3] = '{1'b1, 1'b1, 1'b1, 16'h4444, 1'b0, 1'b1, 1'b0, 1'b0};
    t2[4] = '{1'b0, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b1, 1'b0, 1'b0};
    t2[5] = '{1'b1, 1'b1, 1'b1, 16'h3333, 1'b0, 1'b1, 1'b0, 1'b0};
    t2[6] = '{1'b1, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b0};
    t2[7] = '{1'b1, 1'b0, 1'b1, 16'h1111, 1'b1, 1'b1, 1'b0, 1'b0};
    t2[8] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};

    #12;
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset done", 32'(done_o), 32'd0);
    chk("reset valid", 32'(valid_o), 32'd0);
    chk("reset rdreq", 32'(lifo_rdreq_o), 32'd0);
    chk("reset last", 32'(last_o), 32'd0);
    chk("reset data", 32'(data_o), 32'd0);
    @(posedge clk); #1;
    srst_i = 1'b0;

    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    do_start(9'd4);
    for (int i = 0; i < 7; i++) apply_vec(t1[i], "full_rate", i);
    chk("full_rate usedw", 32'(lcnt), 32'd0);

    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    do_start(9'd4);
    for (int i = 0; i < 9; i++) apply_vec(t2[i], "backpressure", i);
    chk("backpressure usedw", 32'(lcnt), 32'd0);

    push(16'h0A01); push(16'h0A02); push(16'h0A03);
    run_burst(9'd10, 1'b0, 1'b0, 1'b1, "clipped");

    push(16'h7777);
    run_burst(9'd0, 1'b0, 1'b0, 1'b0, "len_zero");
    chk("len_zero usedw", 32'(lcnt), 32'd1);
    run_burst(9'd1, 1'b0, 1'b0, 1'b0, "single");
    run_burst(9'd5, 1'b0, 1'b0, 1'b1, "empty_lifo");

    for (int i = 0; i < 256; i++) push(16'(16'h8000 + i));
    run_burst(9'd256, 1'b1, 1'b0, 1'b0, "full_depth");
    chk("full_depth empty", 32'(lifo_empty_i), 32'd1);

    for (int i = 0; i < 20; i++) push(16'(16'h3000 + i));
    do_start(9'd20);
    acc = 0;
    for (int cyc = 0; cyc < 200 && acc < 5; cyc++) begin
      @(posedge clk); #1;
      start_i = 1'b0; ready_i = 1'b1;
      #1;
      monitor();
      if (valid_o) begin
        chk($sformatf("pre_reset word%0d", acc), 32'(data_o), 32'(16'h3013 - 16'(acc)));
        acc++;
      end
    end
    chk("pre_reset accepted", 32'(acc), 32'd5);
    #2;
    srst_i = 1'b1;
    #1;
    chk("async busy", 32'(busy_o), 32'd0);
    chk("async done", 32'(done_o), 32'd0);
    chk("async short", 32'(short_o), 32'd0);
    chk("async rdreq", 32'(lifo_rdreq_o), 32'd0);
    chk("async valid", 32'(valid_o), 32'd0);
    chk("async last", 32'(last_o), 32'd0);
    chk("async data", 32'(data_o), 32'd0);
    @(posedge clk); #1;
    srst_i = 1'b0;
    issued = 0; accepted = 0;

    push(16'h5A01); push(16'h5A02);
    run_burst(9'd2, 1'b0, 1'b1, 1'b0, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
